branch_predictor: RTL and testbench

- Fetch-side companion to the branch condition evaluator: predicts branch direction and target at fetch, then consumes the resolved branch outcome from execute.
- Holds a direct-mapped table of 2-bit saturating counters plus a tagged target buffer.
- On resolution, trains the tables and raises a registered mispredict/redirect to the PC logic.
- Sits between the PC register / instruction fetch and the execute-stage condition evaluator.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/sat_ctr2.sv | 19 +
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch opcodes, 2-bit counter encodings and opcode decode.
package cpu_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CTR_W = 2;

  localparam logic [OP_W-1:0] BEQ  = 4'b1000;
  localparam logic [OP_W-1:0] BNE  = 4'b1010;
  localparam logic [OP_W-1:0] BLT  = 4'b0010;
  localparam logic [OP_W-1:0] BGE  = 4'b0011;
  localparam logic [OP_W-1:0] BGTZ = 4'b1100;
  localparam logic [OP_W-1:0] BGT  = 4'b1110;

  typedef enum logic [CTR_W-1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // True for conditional branches that train the predictor.
  function automatic logic is_branch(input logic [OP_W-1:0] opcode);
    logic br;
    case (opcode)
      BEQ, BNE, BLT, BGE, BGTZ, BGT: br = 1'b1;
      default:                       br = 1'b0;
    endcase
    return br;
  endfunction

endpackage

// File: rtl/sat_ctr2.sv
// Combinational next state of a 2-bit saturating direction counter.
module sat_ctr2
  import cpu_pkg::*;
(
  input  logic [CTR_W-1:0] cur,
  input  logic             taken,
  output logic [CTR_W-1:0] nxt_c
);

  always_comb begin
    nxt_c = cur;
    if (taken) begin
      if (cur != ST) nxt_c = CTR_W'(cur + 2'd1);
    end else begin
      if (cur != SNT) nxt_c = CTR_W'(cur - 2'd1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-side direction/target predictor with execute-stage training and redirect.
module branch_predictor
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pred_req,
  input  logic [PC_W-1:0] pred_pc,
  output logic            pred_valid,
  output logic            pred_taken,
  output logic [PC_W-1:0] pred_target,
  input  logic            res_valid,
  input  logic [3:0]      res_opcode,
  input  logic [PC_W-1:0] res_pc,
  input  logic            res_branch,
  input  logic [PC_W-1:0] res_target,
  input  logic            res_pred_taken,
  input  logic [PC_W-1:0] res_pred_target,
  output logic            mispredict,
  output logic [PC_W-1:0] redirect_pc
);

  localparam int unsigned ENTRIES = 2 ** IDX_W;
  localparam int unsigned TAG_W   = PC_W - IDX_W;

  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic [TAG_W-1:0] tag_q [ENTRIES];
  logic [PC_W-1:0]  tgt_q [ENTRIES];
  logic [ENTRIES-1:0] vld_q;

  logic [IDX_W-1:0] p_idx_c;
  logic [TAG_W-1:0] p_tag_c;
  logic             p_hit_c;
  logic             p_taken_c;
  logic [PC_W-1:0]  p_target_c;

  logic [IDX_W-1:0] r_idx_c;
  logic [TAG_W-1:0] r_tag_c;
  logic             upd_c;
  logic             misp_c;
  logic [PC_W-1:0]  redir_c;
  logic [CTR_W-1:0] ctr_cur_c;
  logic [CTR_W-1:0] ctr_nxt_c;

  // Prediction lookup reads current (pre-update) table state.
  always_comb begin
    p_idx_c    = pred_pc[IDX_W-1:0];
    p_tag_c    = pred_pc[PC_W-1:IDX_W];
    p_hit_c    = vld_q[p_idx_c] && (tag_q[p_idx_c] == p_tag_c);
    p_taken_c  = p_hit_c && ctr_q[p_idx_c][CTR_W-1];
    p_target_c = p_taken_c ? tgt_q[p_idx_c] : PC_W'(pred_pc + 1'b1);
  end

  // Resolution decode: only real branches train or redirect.
  always_comb begin
    r_idx_c   = res_pc[IDX_W-1:0];
    r_tag_c   = res_pc[PC_W-1:IDX_W];
    upd_c     = res_valid && is_branch(res_opcode);
    ctr_cur_c = ctr_q[r_idx_c];
    misp_c    = upd_c &&
                ((res_pred_taken != res_branch) ||
                 (res_pred_taken && res_branch && (res_pred_target != res_target)));
    redir_c   = res_branch ? res_target : PC_W'(res_pc + 1'b1);
  end

  sat_ctr2 u_sat_ctr2 (
    .cur   (ctr_cur_c),
    .taken (res_branch),
    .nxt_c (ctr_nxt_c)
  );

  // Table training; a taken outcome also (re)allocates the target entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        ctr_q[i] <= WNT;
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
      vld_q <= '0;
    end else if (upd_c) begin
      ctr_q[r_idx_c] <= ctr_nxt_c;
      if (res_branch) begin
        tgt_q[r_idx_c] <= res_target;
        tag_q[r_idx_c] <= r_tag_c;
        vld_q[r_idx_c] <= 1'b1;
      end
    end
  end

  // Registered prediction outputs; taken/target hold when no request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid  <= 1'b0;
      pred_taken  <= 1'b0;
      pred_target <= '0;
    end else begin
      pred_valid <= pred_req;
      if (pred_req) begin
        pred_taken  <= p_taken_c;
        pred_target <= p_target_c;
      end
    end
  end

  // Single-cycle redirect pulse per qualifying resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict  <= 1'b0;
      redirect_pc <= '0;
    end else begin
      mispredict <= misp_c;
      if (misp_c) redirect_pc <= redir_c;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus randomized traffic.
module tb_branch_predictor;

  localparam int PC_W  = 16;
  localparam int NENT  = 16;

  logic            clk;
  logic            rst_n;
  logic            pred_req;
  logic [PC_W-1:0] pred_pc;
  logic            pred_valid;
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;
  logic            res_valid;
  logic [3:0]      res_opcode;
  logic [PC_W-1:0] res_pc;
  logic            res_branch;
  logic [PC_W-1:0] res_target;
  logic            res_pred_taken;
  logic [PC_W-1:0] res_pred_target;
  logic            mispredict;
  logic [PC_W-1:0] redirect_pc;

  branch_predictor #(.PC_W(16), .IDX_W(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pred_req        (pred_req),
    .pred_pc         (pred_pc),
    .pred_valid      (pred_valid),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .res_valid       (res_valid),
    .res_opcode      (res_opcode),
    .res_pc          (res_pc),
    .res_branch      (res_branch),
    .res_target      (res_target),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .mispredict      (mispredict),
    .redirect_pc     (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          taken;
    logic [15:0] tgt;
  } pexp_t;

  pexp_t       pred_q[$];
  logic [15:0] misp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model: per-entry direction strength 0..3 plus a tagged target.
  int m_ctr [NENT];
  bit m_val [NENT];
  int m_tag [NENT];
  int m_tgt [NENT];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_ctr[i] = 1;
      m_val[i] = 1'b0;
      m_tag[i] = 0;
      m_tgt[i] = 0;
    end
  endfunction

  function automatic bit m_branch(input logic [3:0] op);
    return op inside {4'b1000, 4'b1010, 4'b0010, 4'b0011, 4'b1100, 4'b1110};
  endfunction

  function automatic logic [15:0] next_pc(input logic [15:0] pc);
    return 16'((int'(pc) + 1) % 65536);
  endfunction

  function automatic pexp_t m_predict(input logic [15:0] pc);
    pexp_t e;
    int i;
    i = int'(pc) % NENT;
    e.taken = m_val[i] && (m_tag[i] == int'(pc) / NENT) && (m_ctr[i] >= 2);
    e.tgt   = e.taken ? 16'(m_tgt[i]) : next_pc(pc);
    return e;
  endfunction

  // One cycle of stimulus; expectations go to the scoreboard, then the model trains.
  task automatic cyc(input bit preq, input logic [15:0] ppc,
                     input bit rv, input logic [3:0] op, input logic [15:0] rpc,
                     input bit rb, input logic [15:0] rt,
                     input bit rpt, input logic [15:0] rptg,
                     input bit ovr = 1'b0, input bit ex_t = 1'b0,
                     input logic [15:0] ex_tg = 16'h0);
    pexp_t e;
    int i;
    @(negedge clk);
    pred_req        = preq;
    pred_pc         = ppc;
    res_valid       = rv;
    res_opcode      = op;
    res_pc          = rpc;
    res_branch      = rb;
    res_target      = rt;
    res_pred_taken  = rpt;
    res_pred_target = rptg;
    if (preq) begin
      e = m_predict(ppc);
      if (ovr) begin
        e.taken = ex_t;
        e.tgt   = ex_tg;
      end
      pred_q.push_back(e);
    end
    if (rv && m_branch(op)) begin
      i = int'(rpc) % NENT;
      if ((rpt != rb) || (rpt && rb && (rptg != rt)))
        misp_q.push_back(rb ? rt : next_pc(rpc));
      if (rb) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_val[i] = 1'b1;
        m_tag[i] = int'(rpc) / NENT;
        m_tgt[i] = int'(rt);
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end
  endtask

  task automatic predict(input logic [15:0] pc, input bit t, input logic [15:0] tg);
    cyc(1'b1, pc, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, t, tg);
  endtask

  task automatic resolve(input logic [3:0] op, input logic [15:0] pc, input bit rb,
                         input logic [15:0] rt, input bit rpt, input logic [15:0] rptg);
    cyc(1'b0, 16'h0, 1'b1, op, pc, rb, rt, rpt, rptg);
  endtask

  task automatic idle();
    cyc(1'b0, 16'h0, 1'b0, 4'h0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pred_valid"},  pred_valid,  0);
    chk({tag, "_pred_taken"},  pred_taken,  0);
    chk({tag, "_pred_target"}, pred_target, 0);
    chk({tag, "_mispredict"},  mispredict,  0);
    chk({tag, "_redirect_pc"}, redirect_pc, 0);
  endtask

  function automatic logic [15:0] rand_pc();
    int tg;
    tg = ($urandom_range(0, 7) == 0) ? 4095 : int'($urandom_range(0, 2));
    return 16'(tg * NENT + int'($urandom_range(0, NENT - 1)));
  endfunction

  task automatic random_cycles(input int n);
    logic [3:0]  ops [6];
    logic [15:0] ppc, rpc, rt, rptg;
    logic [3:0]  op;
    bit          preq, rv, rb, rpt;
    pexp_t       mp;
    ops[0] = 4'b1000; ops[1] = 4'b1010; ops[2] = 4'b0010;
    ops[3] = 4'b0011; ops[4] = 4'b1100; ops[5] = 4'b1110;
    for (int k = 0; k < n; k++) begin
      preq = ($urandom_range(0, 3) != 0);
      ppc  = rand_pc();
      rv   = ($urandom_range(0, 2) != 0);
      rpc  = ($urandom_range(0, 3) == 0) ? ppc : rand_pc();
      op   = ($urandom_range(0, 9) < 7) ? ops[$urandom_range(0, 5)] : 4'($urandom_range(0, 15));
      rb   = $urandom_range(0, 1) == 1;
      rt   = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 63)) : 16'($urandom);
      mp   = m_predict(rpc);
      rpt  = ($urandom_range(0, 1) == 1) ? mp.taken : ($urandom_range(0, 1) == 1);
      rptg = ($urandom_range(0, 2) == 0) ? 16'($urandom) : (rpt ? rt : mp.tgt);
      cyc(preq, ppc, rv, op, rpc, rb, rt, rpt, rptg);
    end
  endtask

  // Monitor: pop and compare whenever the DUT presents a prediction or redirect.
  initial begin : monitor
    pexp_t e;
    logic [15:0] r;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        if (pred_valid) begin
          if (pred_q.size() == 0) chk("pred_unexpected", 1, 0);
          else begin
            e = pred_q.pop_front();
            chk("pred_taken", pred_taken, e.taken);
            chk("pred_target", pred_target, e.tgt);
          end
        end
        if (mispredict) begin
          if (misp_q.size() == 0) chk("mispredict_unexpected", 1, 0);
          else begin
            r = misp_q.pop_front();
            chk("redirect_pc", redirect_pc, r);
          end
        end
      end
    end
  end

  initial begin : stimulus
    rst_n = 1'b0;
    pred_req = 1'b0; pred_pc = '0;
    res_valid = 1'b0; res_opcode = '0; res_pc = '0; res_branch = 1'b0;
    res_target = '0; res_pred_taken = 1'b0; res_pred_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Cold prediction.
    predict(16'h0010, 1'b0, 16'h0011);
    // Two taken BEQ trainings, then a taken prediction.
    resolve(4'b1000, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
    resolve(4'b1000, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000);
    predict(16'h0010, 1'b1, 16'h0040);
    // Saturate, then hysteresis on not-taken.
    resolve(4'b1000, 16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
    resolve(4'b1000, 16'h0010, 1'b1, 16'h0040, 1'b1, 16'h0040);
    resolve(4'b1000, 16'h0010, 1'b0, 16'h0040, 1'b1, 16'h0040);
    predict(16'h0010, 1'b1, 16'h0040);
    resolve(4'b1000, 16'h0010, 1'b0, 16'h0040, 1'b1, 16'h0040);
    predict(16'h0010, 1'b0, 16'h0011);
    // Redirect wraps past the top of the address space.
    resolve(4'b1010, 16'hFFFF, 1'b0, 16'h5555, 1'b1, 16'h1234);
    predict(16'hFFFF, 1'b0, 16'h0000);
    // Non-branch opcode must neither train nor redirect.
    resolve(4'b0001, 16'h0010, 1'b1, 16'h0099, 1'b0, 16'h0000);
    predict(16'h0010, 1'b0, 16'h0011);
    // Same-index predict and update on one edge: prediction sees old state.
    cyc(1'b1, 16'h0010, 1'b1, 4'b1000, 16'h0010, 1'b1, 16'h0040, 1'b0, 16'h0000,
        1'b1, 1'b0, 16'h0011);
    predict(16'h0010, 1'b1, 16'h0040);
    predict(16'h0020, 1'b0, 16'h0021);
    // Alias retrains the shared entry and evicts the old tag.
    resolve(4'b1110, 16'h0020, 1'b1, 16'h0077, 1'b0, 16'h0000);
    predict(16'h0010, 1'b0, 16'h0011);
    predict(16'h0020, 1'b1, 16'h0077);

    random_cycles(600);

    // Reset mid-flight drops the pending prediction, redirect and training.
    @(negedge clk);
    pred_req = 1'b1; pred_pc = 16'h0020;
    res_valid = 1'b1; res_opcode = 4'b1000; res_pc = 16'h0030;
    res_branch = 1'b1; res_target = 16'h0123;
    res_pred_taken = 1'b0; res_pred_target = 16'h0000;
    #2;
    rst_n = 1'b0;
    pred_req = 1'b0; res_valid = 1'b0;
    pred_q.delete();
    misp_q.delete();
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    predict(16'h0020, 1'b0, 16'h0021);
    predict(16'h0030, 1'b0, 16'h0031);

    random_cycles(200);
    repeat (3) idle();

    chk("pred_queue_drained", 32'(pred_q.size()), 0);
    chk("misp_queue_drained", 32'(misp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
